// File: rtl/tisaradc_offset_cal.sv
// tisaradc_offset_cal
//   Foreground offset-calibration sequencer for a time-interleaved SAR ADC.
//   For every slice selected in slice_mask it runs a TRIM_BITS-step
//   successive-approximation search on the offset trim. The ADC input is held
//   at common mode throughout, so each slice's averaged output should sit at
//   mid-code once the search is complete.
//
// Ports
//   clk         ADC output clock
//   rst_n       synchronous active-low reset
//   start       one-cycle pulse that begins calibration; only accepted in IDLE
//   abort       stops calibration; takes priority over start
//   slice_mask  1 = calibrate slice i; captured when start is accepted
//   adc_valid   adc_data carries a new sample set this cycle
//   adc_data    packed slice outputs, slice i at [i*BITS +: BITS]
//   osp         packed positive offset trim, slice i at [i*TRIM_BITS +: TRIM_BITS]
//   osm         packed negative offset trim, always ~osp
//   busy        high while a calibration run is in progress
//   done        one-cycle pulse at the end of a run that was not aborted
//   sat         slice i finished on code all-zeros or all-ones
module tisaradc_offset_cal #(
  parameter int WAYS      = 8,
  parameter int BITS      = 9,
  parameter int TRIM_BITS = 8,
  parameter int SETTLE    = 16,
  parameter int LOG2_AVG  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [WAYS-1:0]           slice_mask,
  input  logic                      adc_valid,
  input  logic [WAYS*BITS-1:0]      adc_data,
  output logic [WAYS*TRIM_BITS-1:0] osp,
  output logic [WAYS*TRIM_BITS-1:0] osm,
  output logic                      busy,
  output logic                      done,
  output logic [WAYS-1:0]           sat
);

  localparam int SL_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int K_W   = (TRIM_BITS > 1) ? $clog2(TRIM_BITS) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int SMP_W = LOG2_AVG + 1;
  localparam int ACC_W = BITS + LOG2_AVG;

  // Sum of 2**LOG2_AVG samples that all sit exactly at mid-code.
  localparam logic [ACC_W-1:0]     ACC_TGT  = ACC_W'(1) << (BITS - 1 + LOG2_AVG);
  localparam logic [SMP_W-1:0]     SMP_LAST = SMP_W'((1 << LOG2_AVG) - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [K_W-1:0]       K_TOP    = K_W'(TRIM_BITS - 1);
  localparam logic [TRIM_BITS-1:0] TRIM_MID = TRIM_BITS'(1) << (TRIM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_LOAD, S_SETTLE, S_ACCUM, S_DECIDE, S_FINISH
  } state_t;

  state_t               state_reg, state_next;
  logic [TRIM_BITS-1:0] osp_reg   [WAYS];
  logic [TRIM_BITS-1:0] osp_next  [WAYS];
  logic [WAYS-1:0]      mask_reg, mask_next;
  logic [WAYS-1:0]      fin_reg, fin_next;
  logic [WAYS-1:0]      sat_reg, sat_next;
  logic [SL_W-1:0]      slice_reg, slice_next;
  logic [K_W-1:0]       k_reg, k_next;
  logic [TRIM_BITS-1:0] base_reg, base_next;
  logic [TRIM_BITS-1:0] orig_reg, orig_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [SMP_W-1:0]     smp_reg, smp_next;
  logic [ACC_W-1:0]     acc_reg, acc_next;

  logic [BITS-1:0]      adc_slice [WAYS];
  logic [WAYS-1:0]      pend;
  logic [SL_W-1:0]      sel_idx;
  logic                 sel_found;
  logic [TRIM_BITS-1:0] trial;
  logic [TRIM_BITS-1:0] new_base;
  logic                 in_slice;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_slice
      assign adc_slice[gi]                         = adc_data[gi*BITS +: BITS];
      assign osp[gi*TRIM_BITS +: TRIM_BITS]        = osp_reg[gi];
      assign osm[gi*TRIM_BITS +: TRIM_BITS]        = ~osp_reg[gi];
    end
  endgenerate

  assign busy = (state_reg != S_IDLE) && (state_reg != S_FINISH);
  assign done = (state_reg == S_FINISH);
  assign sat  = sat_reg;

  // Lowest-index slice that is masked and not yet finished.
  assign pend = mask_reg & ~fin_reg;
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_idx   = SL_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign trial    = base_reg | (TRIM_BITS'(1) << k_reg);
  // Output above mid-code means the trial bit pushed the slice too high.
  assign new_base = (acc_reg > ACC_TGT) ? base_reg : trial;
  // States in which osp of the current slice differs from its saved code.
  assign in_slice = (state_reg == S_LOAD) || (state_reg == S_SETTLE) ||
                    (state_reg == S_ACCUM) || (state_reg == S_DECIDE);

  always_comb begin
    state_next = state_reg;
    osp_next   = osp_reg;
    mask_next  = mask_reg;
    fin_next   = fin_reg;
    sat_next   = sat_reg;
    slice_next = slice_reg;
    k_next     = k_reg;
    base_next  = base_reg;
    orig_next  = orig_reg;
    cnt_next   = cnt_reg;
    smp_next   = smp_reg;
    acc_next   = acc_reg;

    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          mask_next  = slice_mask;
          fin_next   = '0;
          sat_next   = '0;
          state_next = S_SEL;
        end
      end
      S_SEL: begin
        if (sel_found) begin
          slice_next = sel_idx;
          orig_next  = osp_reg[sel_idx];
          base_next  = '0;
          k_next     = K_TOP;
          state_next = S_LOAD;
        end else begin
          state_next = S_FINISH;
        end
      end
      S_LOAD: begin
        osp_next[slice_reg] = trial;
        cnt_next   = '0;
        smp_next   = '0;
        acc_next   = '0;
        state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = S_ACCUM;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_ACCUM: begin
        if (adc_valid) begin
          acc_next = acc_reg + ACC_W'(adc_slice[slice_reg]);
          smp_next = smp_reg + SMP_W'(1);
          if (smp_reg == SMP_LAST) begin
            state_next = S_DECIDE;
          end
        end
      end
      S_DECIDE: begin
        osp_next[slice_reg] = new_base;
        base_next = new_base;
        if (k_reg != '0) begin
          k_next     = k_reg - K_W'(1);
          state_next = S_LOAD;
        end else begin
          fin_next[slice_reg] = 1'b1;
          sat_next[slice_reg] = (new_base == '0) || (new_base == '1);
          state_next = S_SEL;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort discards the partial search of the current slice only; slices
    // finished earlier in the run keep their new codes and sat flags.
    if (abort && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
      fin_next   = fin_reg;
      sat_next   = sat_reg;
      if (in_slice) begin
        osp_next[slice_reg] = orig_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      for (int i = 0; i < WAYS; i++) begin
        osp_reg[i] <= TRIM_MID;
      end
      mask_reg  <= '0;
      fin_reg   <= '0;
      sat_reg   <= '0;
      slice_reg <= '0;
      k_reg     <= '0;
      base_reg  <= '0;
      orig_reg  <= '0;
      cnt_reg   <= '0;
      smp_reg   <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      osp_reg   <= osp_next;
      mask_reg  <= mask_next;
      fin_reg   <= fin_next;
      sat_reg   <= sat_next;
      slice_reg <= slice_next;
      k_reg     <= k_next;
      base_reg  <= base_next;
      orig_reg  <= orig_next;
      cnt_reg   <= cnt_next;
      smp_reg   <= smp_next;
      acc_reg   <= acc_next;
    end
  end

endmodule
